// File: rtl/axi_line_fill_pkg.sv
// Shared types and AXI constants for the instruction-cache line fill engine.
package axi_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Beats per cache line: 512-bit line over a 64-bit R channel.
  localparam int BEATS = 8;

endpackage

// File: rtl/axi_line_fill.sv
// Instruction-cache line fill engine: on a miss, issues one AXI4 INCR read
// burst for the enclosing line, assembles the beats into a line register and
// strobes it into the cache for one cycle.
// Optional build macro LINE_FILL_ERR_CHECK_EN enables R-channel error checking
// (bad response or misplaced RLAST sets a sticky error and drops the write).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for a miss; i_start captures the line address
// ADDR  | AR request presented, held until accepted
// DATA  | collecting beats; the 8th accepted beat ends the burst
// DONE  | single cycle; line written to the cache unless errored
module axi_line_fill
  import axi_line_fill_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int BLOCK_WIDTH    = 512,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic                      i_start,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_busy,
  output logic [BLOCK_WIDTH-1:0]    o_instr_block,
  output logic                      o_instr_we,
  output logic                      o_error,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [CNT_W-1:0]        r_beat;
  logic [BLOCK_WIDTH-1:0]  r_block;
  logic                    w_fill_start;
  logic                    w_beat_acc;
  logic                    w_last_acc;
  logic                    w_fill_bad;

  assign w_fill_start = (r_state == ST_IDLE) && i_start;
  assign w_beat_acc   = (r_state == ST_DATA) && i_rvalid;
  // The beat counter alone decides the end of the burst; RLAST is only checked.
  assign w_last_acc   = w_beat_acc && (r_beat == LAST_BEAT);

`ifdef LINE_FILL_ERR_CHECK_EN
  logic r_error;
  logic r_fill_err;
  logic w_beat_err;

  assign w_beat_err = (i_rresp != RESP_OKAY) || (i_rlast != (r_beat == LAST_BEAT));

  // Sticky error for software plus a per-fill flag that vetoes this fill's write.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_error    <= 1'b0;
      r_fill_err <= 1'b0;
    end else if (w_fill_start) begin
      r_fill_err <= 1'b0;
    end else if (w_beat_acc && w_beat_err) begin
      r_fill_err <= 1'b1;
      r_error    <= 1'b1;
    end
  end

  assign w_fill_bad = r_fill_err;
  assign o_error    = r_error;
`else
  logic w_unused_rsp;

  assign w_unused_rsp = ^{i_rresp, i_rlast};
  assign w_fill_bad   = 1'b0;
  assign o_error      = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_instr_we  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        o_arvalid = 1'b1;
        if (i_arready) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_rready = 1'b1;
        if (w_last_acc) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_instr_we  = !w_fill_bad;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Line address capture, beat counter and line assembly.
  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      r_addr  <= '0;
      r_beat  <= '0;
      r_block <= '0;
    end else begin
      if (w_fill_start) begin
        r_addr <= {i_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
        r_beat <= '0;
      end
      if (w_beat_acc) begin
        r_block[r_beat*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign o_araddr      = r_addr;
  assign o_arlen       = 8'(BEATS - 1);
  assign o_arsize      = SIZE_8B;
  assign o_arburst     = BURST_INCR;
  assign o_instr_block = r_block;

endmodule
